// File: rtl/asmd_seq_multiplier_if.sv
// asmd_seq_multiplier_if: start/ready handshake plus operand and result bus
interface asmd_seq_multiplier_if #(
  parameter int word_length = 8
);
  logic start;
  logic signed_mode;
  logic ready;
  logic done;
  logic [word_length-1:0] word0;
  logic [word_length-1:0] word1;
  logic [2*word_length-1:0] product;
  modport master(output start, signed_mode, word0, word1, input product, ready, done);
  modport slave(input start, signed_mode, word0, word1, output product, ready, done);
endinterface

// File: rtl/asmd_seq_multiplier.sv
// asmd_seq_multiplier: shift-and-add signed/unsigned multiplier with early termination
module asmd_seq_multiplier #(
  parameter int word_length = 8
) (
  input logic clk,
  input logic reset,
  asmd_seq_multiplier_if.slave bus
);
  localparam int W = word_length;
  localparam int CW = $clog2(W);
  typedef enum logic [1:0] {INIT, IDLE, BUSY, FINISH} state_t;
  state_t state_q, state_d;
  logic [2*W-1:0] mcand_q, mcand_d, acc_q, acc_d, product_q, product_d;
  logic [W-1:0] mplier_q, mplier_d, mag0, mag1;
  logic [CW-1:0] count_q, count_d;
  logic neg_q, neg_d, ready_q, ready_d, done_q, done_d;
  // The magnitude of the most negative value still fits unsigned in W bits
  assign mag0 = (bus.signed_mode && bus.word0[W-1]) ? -bus.word0 : bus.word0;
  assign mag1 = (bus.signed_mode && bus.word1[W-1]) ? -bus.word1 : bus.word1;
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    mplier_d = mplier_q;
    acc_d = acc_q;
    count_d = count_q;
    neg_d = neg_q;
    product_d = product_q;
    done_d = 1'b0;
    case (state_q)
      INIT: state_d = IDLE;
      IDLE: if (bus.start) begin
        mcand_d = {{W{1'b0}}, mag0};
        mplier_d = mag1;
        acc_d = '0;
        count_d = '0;
        neg_d = bus.signed_mode & (bus.word0[W-1] ^ bus.word1[W-1]);
        state_d = BUSY;
      end
      BUSY: begin
        acc_d = mplier_q[0] ? acc_q + mcand_q : acc_q;
        mcand_d = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d = count_q + 1'b1;
        state_d = (mplier_d == '0 || count_q == CW'(W - 1)) ? FINISH : BUSY;
      end
      FINISH: begin
        product_d = neg_q ? -acc_q : acc_q;
        done_d = 1'b1;
        state_d = IDLE;
      end
    endcase
    ready_d = state_d == IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= INIT;
      mcand_q <= '0;
      mplier_q <= '0;
      acc_q <= '0;
      count_q <= '0;
      neg_q <= 1'b0;
      product_q <= '0;
      ready_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mplier_q <= mplier_d;
      acc_q <= acc_d;
      count_q <= count_d;
      neg_q <= neg_d;
      product_q <= product_d;
      ready_q <= ready_d;
      done_q <= done_d;
    end
  assign bus.product = product_q;
  assign bus.ready = ready_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_asmd_seq_multiplier.sv
// tb_asmd_seq_multiplier: table-driven vectors with a done-triggered scoreboard, W=4
module tb_asmd_seq_multiplier;
  logic clk = 1'b0;
  logic reset = 1'b0;
  asmd_seq_multiplier_if #(.word_length(4)) bus();
  asmd_seq_multiplier #(.word_length(4)) dut(.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic sm;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] p;
    int lat;
  } vec_t;
  vec_t tbl[9];
  int passed = 0;
  int total = 0;
  int done_cnt = 0;
  logic [7:0] sb[$];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  function automatic logic [7:0] ref_mul(input logic sm, input logic [3:0] a, input logic [3:0] b);
    int sa, sb_, x;
    sa = sm ? {{28{a[3]}}, a} : {28'b0, a};
    sb_ = sm ? {{28{b[3]}}, b} : {28'b0, b};
    x = sa * sb_;
    return x[7:0];
  endfunction
  always @(negedge clk)
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else chk("product", {24'b0, bus.product}, {24'b0, sb.pop_front()});
      chk("ready_with_done", {31'b0, bus.ready}, 32'd1);
      done_cnt++;
    end
  // Latency counts edges from the start edge (inclusive) until ready is seen high
  task automatic run_op(input string nm, input logic sm, input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] exp, input int lat, input bit poke);
    int n, d0;
    d0 = done_cnt;
    sb.push_back(exp);
    bus.start = 1'b1;
    bus.signed_mode = sm;
    bus.word0 = a;
    bus.word1 = b;
    @(negedge clk);
    bus.start = poke;
    bus.word0 = ~a;
    bus.word1 = ~b;
    bus.signed_mode = ~sm;
    chk({nm, "_ready_low"}, {31'b0, bus.ready}, 32'd0);
    n = 1;
    while (bus.ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      bus.start = 1'b0;
      n++;
    end
    #1;
    chk({nm, "_latency"}, n, lat);
    chk({nm, "_done_count"}, done_cnt - d0, 32'd1);
    @(negedge clk);
    chk({nm, "_done_fell"}, {31'b0, bus.done}, 32'd0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n, m, d0;
    tbl[0] = '{1'b0, 4'h5, 4'h3, 8'h0F, 4};
    tbl[1] = '{1'b0, 4'hF, 4'hF, 8'hE1, 6};
    tbl[2] = '{1'b0, 4'h7, 4'h0, 8'h00, 3};
    tbl[3] = '{1'b1, 4'hD, 4'h5, 8'hF1, 5};
    tbl[4] = '{1'b1, 4'h8, 4'h8, 8'h40, 6};
    tbl[5] = '{1'b1, 4'h7, 4'hF, 8'hF9, 3};
    tbl[6] = '{1'b1, 4'h8, 4'h7, 8'hC8, 5};
    tbl[7] = '{1'b0, 4'h8, 4'h8, 8'h40, 6};
    tbl[8] = '{1'b0, 4'h1, 4'hF, 8'h0F, 6};
    bus.start = 1'b0;
    bus.signed_mode = 1'b0;
    bus.word0 = '0;
    bus.word1 = '0;
    #2 reset = 1'b1;
    #1;
    chk("rst_product", {24'b0, bus.product}, 32'd0);
    chk("rst_ready", {31'b0, bus.ready}, 32'd0);
    chk("rst_done", {31'b0, bus.done}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1 chk("init_ready", {31'b0, bus.ready}, 32'd0);
    @(negedge clk);
    chk("idle_ready", {31'b0, bus.ready}, 32'd1);
    for (int i = 0; i < 9; i++)
      run_op($sformatf("vec%0d", i), tbl[i].sm, tbl[i].a, tbl[i].b, tbl[i].p, tbl[i].lat, 1'b0);
    run_op("busy_poke", 1'b0, 4'h5, 4'h3, ref_mul(1'b0, 4'h5, 4'h3), 4, 1'b1);
    bus.start = 1'b1;
    bus.signed_mode = 1'b0;
    bus.word0 = 4'hF;
    bus.word1 = 4'hF;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    d0 = done_cnt;
    #2 reset = 1'b1;
    #1;
    chk("abort_product", {24'b0, bus.product}, 32'd0);
    chk("abort_ready", {31'b0, bus.ready}, 32'd0);
    chk("abort_done", {31'b0, bus.done}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("abort_ready_back", {31'b0, bus.ready}, 32'd1);
    chk("abort_no_done", done_cnt - d0, 32'd0);
    run_op("after_abort", 1'b0, 4'h2, 4'h2, 8'h04, 4, 1'b0);
    d0 = done_cnt;
    sb.push_back(ref_mul(1'b0, 4'h3, 4'h3));
    sb.push_back(ref_mul(1'b0, 4'h2, 4'h6));
    bus.start = 1'b1;
    bus.signed_mode = 1'b0;
    bus.word0 = 4'h3;
    bus.word1 = 4'h3;
    @(negedge clk);
    #1;
    bus.word0 = 4'h2;
    bus.word1 = 4'h6;
    n = 1;
    while (done_cnt == d0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("b2b_first_latency", n, 4);
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_second_started", {31'b0, bus.ready}, 32'd0);
    chk("b2b_done_fell", {31'b0, bus.done}, 32'd0);
    m = 1;
    while (done_cnt == d0 + 1 && m < 20) begin
      @(negedge clk);
      #1;
      m++;
    end
    chk("b2b_second_latency", m, 5);
    chk("b2b_done_count", done_cnt - d0, 32'd2);
    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
